// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction immediate encoder: format codes,
// signed range limits per format and a range helper.
package inst_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;
  localparam int signed J_MIN  = -1048576;
  localparam int signed J_MAX  = 1048574;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  function automatic logic in_range(logic [31:0] imm, int signed lo, int signed hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational immediate packer: scatters a signed immediate into the I/S/B/J
// fields of a template word, or flags it and passes the template through.
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    inst = base;
    err  = 1'b0;
    case (sel)
      IMM_I: begin
        if (in_range(imm, IS_MIN, IS_MAX)) inst[31:20] = imm[11:0];
        else err = 1'b1;
      end
      IMM_S: begin
        if (in_range(imm, IS_MIN, IS_MAX)) begin
          inst[31:25] = imm[11:5];
          inst[11:7]  = imm[4:0];
        end else err = 1'b1;
      end
      IMM_B: begin
        if (in_range(imm, B_MIN, B_MAX) && !imm[0]) begin
          inst[31]    = imm[12];
          inst[30:25] = imm[10:5];
          inst[11:8]  = imm[4:1];
          inst[7]     = imm[11];
        end else err = 1'b1;
      end
      IMM_J: begin
        if (in_range(imm, J_MIN, J_MAX) && !imm[0]) begin
          inst[31]    = imm[20];
          inst[30:21] = imm[10:1];
          inst[20]    = imm[11];
          inst[19:12] = imm[19:12];
        end else err = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready instruction encoder: packs immediates into template
// words and emits them with sequential, wrapping instruction-memory addresses.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MEM_DEPTH = 256,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] pack_inst;
  logic        pack_err;
  logic        s1_valid;
  enc_word_t   s1_word;
  logic        s2_free;
  logic        s1_advance;
  logic        out_fire;
  logic [AW-1:0] addr_idx;

  imm_pack u_pack (
    .sel  (in_sel),
    .imm  (in_imm),
    .base (in_base),
    .inst (pack_inst),
    .err  (pack_err)
  );

  assign s2_free    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_free;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_fire   = out_valid && out_ready;

  // Word index wraps naturally at MEM_DEPTH because MEM_DEPTH is a power of two.
  assign out_addr = ADDR_BASE + {{(30 - AW){1'b0}}, addr_idx, 2'b00};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
      addr_idx  <= '0;
      err_cnt   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        // NOTE: s1_word has no reset; its contents are only observed while s1_valid is set.
        if (in_valid) s1_word <= '{inst: pack_inst, err: pack_err};
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_inst <= s1_word.inst;
          out_err  <= s1_word.err;
        end
      end
      if (out_fire) begin
        addr_idx <= addr_idx + AW'(1);
        if (out_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder: packing table, latency, backpressure,
// address wrap, mid-stream reset and error-counter saturation.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam logic [31:0] ADDR_BASE = 32'h0000_1000;
  localparam int          MEM_DEPTH = 16;
  localparam int          ERR_W     = 4;
  localparam int          NVEC      = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_sel = '0;
  logic [31:0]      in_imm = '0;
  logic [31:0]      in_base = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_inst;
  logic [31:0]      out_addr;
  logic             out_err;
  logic [ERR_W-1:0] err_cnt;

  inst_encoder #(
    .ADDR_BASE (ADDR_BASE),
    .MEM_DEPTH (MEM_DEPTH),
    .ERR_W     (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int n_out = 0;
  logic [ERR_W-1:0] exp_err_cnt = '0;
  bit bp_en = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst, prev_addr;
  logic        prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard compare on each transfer plus stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_inst", out_inst, prev_inst);
        check("stall_err", 32'(out_err), 32'(prev_err));
        check("stall_addr", out_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", out_inst);
        end else begin
          e_mon = exp_q.pop_front();
          check("out_inst", out_inst, e_mon.inst);
          check("out_err", 32'(out_err), 32'(e_mon.err));
          check("out_addr", out_addr, ADDR_BASE + 32'(exp_idx * 4));
          check("err_cnt_run", 32'(err_cnt), 32'(exp_err_cnt));
          exp_idx = (exp_idx + 1) % MEM_DEPTH;
          if (e_mon.err && exp_err_cnt != '1) exp_err_cnt = exp_err_cnt + 1'b1;
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      prev_err   = out_err;
      prev_addr  = out_addr;
    end
  end

  // Random consumer backpressure, changed just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Drives one request; returns 1 ns after the accepting edge.
  task automatic push(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] exp_inst, input logic exp_err);
    int  waited = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_imm   = imm;
    in_base  = base;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{inst: exp_inst, err: exp_err});
        done = 1'b1;
      end else if (++waited > 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_vec(input int i);
    push(vecs[i].sel, vecs[i].imm, vecs[i].base, vecs[i].exp_inst, vecs[i].exp_err);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_idx = 0;
    exp_err_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_out;
    vecs[0]  = '{IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{IMM_S, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0};
    vecs[2]  = '{IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    vecs[3]  = '{IMM_J, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0};
    vecs[4]  = '{IMM_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1};
    vecs[5]  = '{IMM_I, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    vecs[6]  = '{IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1};
    vecs[7]  = '{IMM_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    vecs[8]  = '{IMM_S, 32'hFFFF_F7FF, 32'h0000_0023, 32'h0000_0023, 1'b1};
    vecs[9]  = '{IMM_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
    vecs[10] = '{IMM_B, 32'h0000_1000, 32'h0000_0063, 32'h0000_0063, 1'b1};
    vecs[11] = '{IMM_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};
    vecs[12] = '{IMM_J, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0};
    vecs[13] = '{IMM_J, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};
    vecs[14] = '{IMM_J, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1};
    vecs[15] = '{IMM_J, 32'h0000_0005, 32'h0000_006F, 32'h0000_006F, 1'b1};
    vecs[16] = '{3'b111, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[17] = '{3'b000, 32'h0000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[18] = '{IMM_S, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0};
    vecs[19] = '{IMM_I, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, ADDR_BASE);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Two-cycle latency for the first word
    push_vec(0);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain(50);

    // Packing table, back-to-back at full rate
    for (int i = 0; i < NVEC; i++) push_vec(i);
    drain(100);
    check("err_cnt_table", 32'(err_cnt), 32'd8);

    // Reset with two words in flight under a stalled consumer
    out_ready = 1'b0;
    push_vec(1);
    push_vec(4);
    do_reset();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_out_addr", out_addr, ADDR_BASE);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Address wrap: MEM_DEPTH+2 words from ADDR_BASE
    base_out = n_out;
    for (int i = 0; i < MEM_DEPTH + 2; i++) push_vec(i % NVEC);
    drain(100);
    check("wrap_count", 32'(n_out - base_out), 32'(MEM_DEPTH + 2));
    check("wrap_final_addr", out_addr, ADDR_BASE + 32'd8);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < (1 << ERR_W) + 3; i++)
      push(3'b111, 32'(i), 32'hDEAD_0000 + 32'(i), 32'hDEAD_0000 + 32'(i), 1'b1);
    drain(100);
    check("err_cnt_saturated", 32'(err_cnt), 32'h0000_000F);

    // Random backpressure, 1000 words
    do_reset();
    base_out = n_out;
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) push_vec(i % NVEC);
    drain(5000);
    bp_en = 1'b0;
    out_ready = 1'b1;
    check("bp_word_count", 32'(n_out - base_out), 32'd1000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
